// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: memory opcodes, FSM state encoding
// and opcode classification helpers.
package mem_stage_pkg;

  localparam logic [4:0] ALU_ADDITION = 5'd0;
  localparam logic [4:0] ALU_LB       = 5'd24;
  localparam logic [4:0] ALU_LH       = 5'd25;
  localparam logic [4:0] ALU_LW       = 5'd26;
  localparam logic [4:0] ALU_LBU      = 5'd27;
  localparam logic [4:0] ALU_LHU      = 5'd28;
  localparam logic [4:0] ALU_SB       = 5'd29;
  localparam logic [4:0] ALU_SH       = 5'd30;
  localparam logic [4:0] ALU_SW       = 5'd31;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Memory opcodes occupy the top of the 5-bit code space (24..31).
  function automatic logic is_mem_op(input logic [4:0] op);
    return op >= ALU_LB;
  endfunction

  function automatic logic is_load_op(input logic [4:0] op);
    return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  endfunction

  function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      ALU_LH, ALU_LHU, ALU_SH: bad = lo[0];
      ALU_LW, ALU_SW:          bad = (lo != 2'b00);
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data and
// load byte/halfword extraction with sign or zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  function automatic logic signed [31:0] sext8(input logic signed [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  always_comb begin
    byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel    = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    be_o        = 4'b0000;
    wdata_o     = rs2_i;
    load_data_o = rdata_i;

    case (op_i)
      ALU_LB, ALU_LBU, ALU_SB: be_o = 4'b0001 << addr_lo_i;
      ALU_LH, ALU_LHU, ALU_SH: be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      ALU_LW, ALU_SW:          be_o = 4'b1111;
      default:                 be_o = 4'b0000;
    endcase

    case (op_i)
      ALU_SB:  wdata_o = {4{rs2_i[7:0]}};
      ALU_SH:  wdata_o = {2{rs2_i[15:0]}};
      default: wdata_o = rs2_i;
    endcase

    case (op_i)
      ALU_LB:  load_data_o = sext8(byte_sel);
      ALU_LBU: load_data_o = {24'd0, byte_sel};
      ALU_LH:  load_data_o = sext16(half_sel);
      ALU_LHU: load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding, registers the write-back.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_alu_output,
  input  logic        in_dest_register_enable,
  input  logic [4:0]  in_dest_register_number,
  input  logic [4:0]  in_operation,
  input  logic [31:0] in_source2_reg_value,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_enable,
  output logic [4:0]  wb_register_number,
  output logic [31:0] wb_value,
  output logic        misaligned_fault
);

  state_e      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wb_en_q, wb_en_d, fault_q, fault_d;
  logic [4:0]  wb_num_q, wb_num_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [4:0]  op_q, op_d, dest_q, dest_d;
  logic [1:0]  lo_q, lo_d;
  logic        dest_en_q, dest_en_d;

  logic [4:0]  lane_op;
  logic [1:0]  lane_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  // Outside ACCESS the lane logic steers the incoming op; inside, the latched one.
  assign lane_op = (state_q == ACCESS) ? op_q : in_operation;
  assign lane_lo = (state_q == ACCESS) ? lo_q : in_alu_output[1:0];

  mem_lane_align u_align (
    .op_i        (lane_op),
    .addr_lo_i   (lane_lo),
    .rs2_i       (in_source2_reg_value),
    .rdata_i     (dmem_rdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .load_data_o (lane_load)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wb_en_d   = 1'b0;
    wb_num_d  = wb_num_q;
    wb_val_d  = wb_val_q;
    fault_d   = 1'b0;
    op_d      = op_q;
    lo_d      = lo_q;
    dest_d    = dest_q;
    dest_en_d = dest_en_q;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!is_mem_op(in_operation)) begin
          wb_val_d = in_alu_output;
          wb_num_d = in_dest_register_number;
          wb_en_d  = in_dest_register_enable && (in_dest_register_number != 5'd0);
        end else if (is_misaligned(in_operation, in_alu_output[1:0])) begin
          fault_d = 1'b1;
        end else begin
          stall     = 1'b1;
          state_d   = ACCESS;
          op_d      = in_operation;
          lo_d      = in_alu_output[1:0];
          dest_d    = in_dest_register_number;
          dest_en_d = in_dest_register_enable;
          req_d     = 1'b1;
          we_d      = !is_load_op(in_operation);
          addr_d    = {in_alu_output[31:2], 2'b00};
          be_d      = lane_be;
          wdata_d   = lane_wdata;
        end
      end
      ACCESS: begin
        stall = !dmem_ack;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (is_load_op(op_q)) begin
            wb_val_d = lane_load;
            wb_num_d = dest_q;
            wb_en_d  = dest_en_q && (dest_q != 5'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      wb_en_q  <= 1'b0;
      wb_num_q <= 5'd0;
      wb_val_q <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      wb_en_q  <= wb_en_d;
      wb_num_q <= wb_num_d;
      wb_val_q <= wb_val_d;
      fault_q  <= fault_d;
    end
  end

  // Access context is only consumed in ACCESS, so it needs no reset.
  always_ff @(posedge clk) begin
    op_q      <= op_d;
    lo_q      <= lo_d;
    dest_q    <= dest_d;
    dest_en_q <= dest_en_d;
  end

  assign dmem_req           = req_q;
  assign dmem_we            = we_q;
  assign dmem_addr          = addr_q;
  assign dmem_byte_enable   = be_q;
  assign dmem_wdata         = wdata_q;
  assign wb_enable          = wb_en_q;
  assign wb_register_number = wb_num_q;
  assign wb_value           = wb_val_q;
  assign misaligned_fault   = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs and
// memory requests; a negedge monitor pops and compares them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_alu_output = 32'd0;
  logic        in_dest_register_enable = 1'b0;
  logic [4:0]  in_dest_register_number = 5'd0;
  logic [4:0]  in_operation = ALU_ADDITION;
  logic [31:0] in_source2_reg_value = 32'd0;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;
  logic        wb_enable;
  logic [4:0]  wb_register_number;
  logic [31:0] wb_value;
  logic        misaligned_fault;

  mem_stage dut (
    .clk                     (clk),
    .reset                   (reset),
    .in_alu_output           (in_alu_output),
    .in_dest_register_enable (in_dest_register_enable),
    .in_dest_register_number (in_dest_register_number),
    .in_operation            (in_operation),
    .in_source2_reg_value    (in_source2_reg_value),
    .stall                   (stall),
    .dmem_req                (dmem_req),
    .dmem_we                 (dmem_we),
    .dmem_addr               (dmem_addr),
    .dmem_byte_enable        (dmem_byte_enable),
    .dmem_wdata              (dmem_wdata),
    .dmem_rdata              (dmem_rdata),
    .dmem_ack                (dmem_ack),
    .wb_enable               (wb_enable),
    .wb_register_number      (wb_register_number),
    .wb_value                (wb_value),
    .misaligned_fault        (misaligned_fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  num;
    logic [31:0] val;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  req_t cur;
  logic in_req = 1'b0;
  logic cur_ok = 1'b0;
  int   exp_faults = 0;
  int   seen_faults = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_req = 1'b0;
      cur_ok = 1'b0;
    end else begin
      if (wb_enable) begin
        if (wb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got reg %0d value 0x%08h, expected no write-back",
                   wb_register_number, wb_value);
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          check("wb_reg", {27'd0, wb_register_number}, {27'd0, e.num});
          check("wb_value", wb_value, e.val);
        end
      end
      if (dmem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          if (req_q.size() == 0) begin
            tests++;
            fails++;
            cur_ok = 1'b0;
            $display("FAIL req_unexpected: got addr 0x%08h we %0d, expected no request",
                     dmem_addr, dmem_we);
          end else begin
            cur = req_q.pop_front();
            cur_ok = 1'b1;
          end
        end
        if (cur_ok) begin
          check("dmem_we", {31'd0, dmem_we}, {31'd0, cur.we});
          check("dmem_addr", dmem_addr, cur.addr);
          check("dmem_be", {28'd0, dmem_byte_enable}, {28'd0, cur.be});
          if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
        end
      end else begin
        in_req = 1'b0;
        cur_ok = 1'b0;
      end
      if (misaligned_fault) seen_faults++;
    end
  end

  task automatic drive(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic en, input logic [4:0] num);
    in_operation            = op;
    in_alu_output           = addr;
    in_source2_reg_value    = rs2;
    in_dest_register_enable = en;
    in_dest_register_number = num;
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic nonmem(input logic [31:0] val, input logic en, input logic [4:0] num);
    drive(ALU_ADDITION, val, 32'h0, en, num);
    if (en && num != 5'd0) wb_q.push_back('{num: num, val: val});
    #1 check("stall_nonmem", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic misal(input logic [4:0] op, input logic [31:0] addr);
    drive(op, addr, 32'h0, 1'b1, 5'd4);
    exp_faults++;
    #1 check("stall_misaligned", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("fault_pulse", {31'd0, misaligned_fault}, 32'd1);
    check("fault_wb_en", {31'd0, wb_enable}, 32'd0);
    check("fault_no_req", {31'd0, dmem_req}, 32'd0);
  endtask

  task automatic memop(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic en, input logic [4:0] num, input logic [31:0] rdata,
                       input int waits, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic push_wb, input logic [31:0] exp_wb);
    int stall_cnt;
    drive(op, addr, rs2, en, num);
    req_q.push_back('{we: exp_we, addr: exp_addr, be: exp_be, wdata: exp_wdata});
    if (push_wb) wb_q.push_back('{num: num, val: exp_wb});
    #1 check("stall_issue", {31'd0, stall}, 32'd1);
    stall_cnt = 1;
    @(posedge clk); #1;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end else begin
        dmem_rdata = 32'h5A5A_5A5A;
      end
      #1 if (stall) stall_cnt++;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    check("stall_cycles", stall_cnt, waits + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", {28'd0, dmem_byte_enable}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_wb_en", {31'd0, wb_enable}, 32'd0);
    check("rst_wb_reg", {27'd0, wb_register_number}, 32'd0);
    check("rst_wb_value", wb_value, 32'd0);
    check("rst_fault", {31'd0, misaligned_fault}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    nonmem(32'h0000_0010, 1'b1, 5'd5);
    nonmem(32'h0000_0099, 1'b1, 5'd0);
    nonmem(32'h0000_0055, 1'b0, 5'd3);
    memop(ALU_SB, 32'h103, 32'h1234_56AB, 1'b0, 5'd0, 32'h0, 3,
          1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0);
    memop(ALU_LB, 32'h202, 32'h0, 1'b1, 5'd6, 32'h0080_0000, 0,
          1'b0, 32'h200, 4'b0100, 32'h0, 1'b1, 32'hFFFF_FF80);
    memop(ALU_LBU, 32'h202, 32'h0, 1'b1, 5'd7, 32'h0080_0000, 0,
          1'b0, 32'h200, 4'b0100, 32'h0, 1'b1, 32'h0000_0080);
    memop(ALU_LH, 32'h002, 32'h0, 1'b1, 5'd8, 32'h8001_0000, 1,
          1'b0, 32'h000, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001);
    memop(ALU_LHU, 32'h000, 32'h0, 1'b1, 5'd9, 32'h1234_F00D, 0,
          1'b0, 32'h000, 4'b0011, 32'h0, 1'b1, 32'h0000_F00D);
    memop(ALU_LW, 32'h010, 32'h0, 1'b1, 5'd10, 32'hCAFE_F00D, 2,
          1'b0, 32'h010, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D);
    memop(ALU_SH, 32'h00E, 32'hAAAA_5678, 1'b0, 5'd0, 32'h0, 0,
          1'b1, 32'h00C, 4'b1100, 32'h5678_5678, 1'b0, 32'h0);
    memop(ALU_SW, 32'h020, 32'h1122_3344, 1'b0, 5'd0, 32'h0, 1,
          1'b1, 32'h020, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);
    memop(ALU_SB, 32'h001, 32'h0000_00C3, 1'b0, 5'd0, 32'h0, 0,
          1'b1, 32'h000, 4'b0010, 32'hC3C3_C3C3, 1'b0, 32'h0);
    misal(ALU_LW, 32'h006);
    misal(ALU_LH, 32'h005);
    misal(ALU_SH, 32'h101);
    misal(ALU_SW, 32'h102);
    nonmem(32'h0000_0042, 1'b1, 5'd11);
    memop(ALU_LW, 32'h030, 32'h0, 1'b1, 5'd0, 32'hDEAD_BEEF, 0,
          1'b0, 32'h030, 4'b1111, 32'h0, 1'b0, 32'h0);

    // Reset in the second cycle of an outstanding load.
    drive(ALU_LW, 32'h040, 32'h0, 1'b1, 5'd7);
    req_q.push_back('{we: 1'b0, addr: 32'h040, be: 4'b1111, wdata: 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_req_before", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_req", {31'd0, dmem_req}, 32'd0);
    check("abort_addr", dmem_addr, 32'd0);
    check("abort_be", {28'd0, dmem_byte_enable}, 32'd0);
    check("abort_wb_en", {31'd0, wb_enable}, 32'd0);
    check("abort_wb_value", wb_value, 32'd0);
    drive(ALU_ADDITION, 32'h0, 32'h0, 1'b0, 5'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    nonmem(32'h0000_0077, 1'b1, 5'd9);
    nonmem(32'h0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;

    check("fault_count", seen_faults, exp_faults);
    check("wb_queue_left", wb_q.size(), 0);
    check("req_queue_left", req_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline stage after the ALU stage in the RISC-V core. It consumes the ALU stage's registered outputs (result/address, destination register enable and number, operation, source-2 value) and performs loads and stores against a data memory with a req/ack handshake. It stalls upstream while an access is outstanding and presents a registered write-back triple to the register file. Non-memory operations pass through with one cycle of latency.

## Interface
Parameters:
- none. Widths are fixed: 32-bit data, 5-bit register numbers, 5-bit operation.

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high
- in_alu_output  in  32  ALU result; effective address for loads and stores
- in_dest_register_enable  in  1  instruction writes a register
- in_dest_register_number  in  5  destination register
- in_operation  in  5  operation code, passed through from the ALU stage
- in_source2_reg_value  in  32  store data
- stall  out  1  combinational; upstream holds all in_* while high
- dmem_req  out  1  registered access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_byte_enable  out  4  lane strobes, bit n = byte n (little-endian)
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  load word, valid when dmem_ack = 1
- dmem_ack  in  1  access completes this cycle
- wb_enable  out  1  write register file
- wb_register_number  out  5  write-back register
- wb_value  out  32  write-back data
- misaligned_fault  out  1  one-cycle pulse on a misaligned access

## Operation
- Memory opcodes, added to the ALU constants include: ALU_LB=24, ALU_LH=25, ALU_LW=26, ALU_LBU=27, ALU_LHU=28, ALU_SB=29, ALU_SH=30, ALU_SW=31. Every other code is non-memory.
- States: IDLE, ACCESS.
- IDLE, non-memory op: register wb_value <= in_alu_output, wb_register_number <= in_dest_register_number, wb_enable <= in_dest_register_enable && number != x0. stall = 0.
- IDLE, misaligned memory op: no access is issued. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0. misaligned_fault <= 1 for one cycle. wb_enable <= 0. stall = 0.
- IDLE, aligned memory op: stall = 1. Latch the opcode, addr[1:0] and the destination. Drive dmem_req <= 1, dmem_we, dmem_addr = {addr[31:2],2'b00}, byte enables and wdata. wb_enable <= 0. Go to ACCESS.
- ACCESS: stall = !dmem_ack. All in_* are ignored. The dmem_* outputs hold steady until ack.
- ACCESS, on dmem_ack: dmem_req <= 0.
  - Load: wb_value <= extracted and extended data; wb_enable <= latched enable && dest != x0.
  - Store: wb_enable <= 0.
  - In both cases go to IDLE.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Loads:
  - Byte: select rdata[8*addr[1:0]+:8].
  - Halfword: select rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Load byte enables: LB/LBU and LH/LHU use the store patterns above; LW uses 4'b1111. dmem_we = 0.

## Timing
- Non-memory and faulting ops: latency 1; the result is on wb_* the cycle after the op is presented.
- Load or store presented in cycle T:
  - stall = 1 in T.
  - dmem_req = 1 from T+1.
  - The earliest ack is in T+1. Write-back data is valid in T+2, and upstream advances at the end of T+1.
- Each extra wait cycle on ack adds one cycle.
- The memory may assert dmem_ack in the first cycle of dmem_req. dmem_ack outside ACCESS is ignored.
- While stalled, wb_enable = 0, so the register file sees a bubble.
- Reset values: dmem_req 0, dmem_we 0, dmem_addr 0, dmem_byte_enable 0, dmem_wdata 0, wb_enable 0, wb_register_number x0, wb_value 0, misaligned_fault 0. State = IDLE.
- Reset during ACCESS abandons the access: dmem_req drops asynchronously, and the memory must discard the transaction.
- Back-to-back memory ops: the second is accepted in the IDLE cycle after the ack, so each op costs at least 2 cycles.

## Structure
- The memory opcode constants go in the ALU constants include. State encodings (IDLE=1'b0, ACCESS=1'b1) go in the standard constants include.
- One combinational sub-module, mem_lane_align, covers store lane steering/byte enables and load extraction/extension. It takes the opcode, addr[1:0], rs2 and rdata. mem_stage holds the FSM and registers.

## Test plan
- ADDITION result 0x0000_0010 to x5 -> the next cycle wb_enable=1, wb_register_number=5, wb_value=0x10, dmem_req never asserted.
- SB rs2=0x1234_56AB at address 0x103 -> dmem_addr=0x100, be=4'b1000, wdata=0xABAB_ABAB, we=1; ack after 3 wait cycles -> stall high for 4 cycles, wb_enable=0 throughout.
- LB at 0x202 with rdata=0x0080_0000 and immediate ack -> wb_value=0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
- LW at 0x006 -> misaligned_fault pulses for 1 cycle, no dmem_req, wb_enable=0, stall=0.
- LW with dest x0 and rdata=0xDEAD_BEEF -> access occurs, wb_enable=0.
- Reset asserted in the second cycle of ACCESS -> dmem_req=0 immediately, outputs at reset values, a following ADDITION completes normally.
